// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: sizes, NOP encoding and buffer depth.
// Buffer depth is 2 when FETCH_PREFETCH_EN is defined, otherwise 1.
package fetch_stage_pkg;

    localparam int ADDR_SIZE  = 32;
    localparam int INSTR_SIZE = 32;
    localparam logic [INSTR_SIZE-1:0] NOP_ENC = 32'h0000_0013;

`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    localparam int CNT_W  = 4;
    localparam int DROP_W = 8;
    localparam logic [CNT_W:0] DEPTH_CREDITS = (CNT_W+1)'(DEPTH);

    typedef struct packed {
        logic [ADDR_SIZE-1:0]  pc;
        logic [INSTR_SIZE-1:0] instr;
    } fetch_entry_t;

    localparam fetch_entry_t ENTRY_ZERO = '{pc: {ADDR_SIZE{1'b0}}, instr: {INSTR_SIZE{1'b0}}};

    function automatic logic [ADDR_SIZE-1:0] align_word(input logic [ADDR_SIZE-1:0] addr);
        return {addr[ADDR_SIZE-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_buffer.sv
// fetch_buffer: small circular FIFO of {pc, instr} entries with clear.
// Push and pop in the same cycle are both honoured, also when full.
module fetch_buffer
    import fetch_stage_pkg::*;
#(
    parameter int DEPTH_P = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  fetch_entry_t     wdata_i,
    output fetch_entry_t     rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;

    fetch_entry_t     mem_q [DEPTH_P];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_pop_s;
    logic             do_push_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH_P - 1)) ? {PTR_W{1'b0}} : ptr + 1'b1;
    endfunction

    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && ((count_q < CNT_W'(DEPTH_P)) || do_pop_s);
    assign rdata_o   = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Storage, pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH_P; i++) begin
                mem_q[i] <= ENTRY_ZERO;
            end
        end else if (clear_i) begin
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop_s) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited word fetch with in-order responses,
// redirect flush with stale-response dropping. Depth set by FETCH_PREFETCH_EN.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [ADDR_SIZE-1:0]  RESET_PC  = 32'h0000_0000,
    parameter logic [INSTR_SIZE-1:0] NOP_INSTR = NOP_ENC
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [ADDR_SIZE-1:0]  redirectPC,
    output logic                  imemReq,
    output logic [ADDR_SIZE-1:0]  imemAddr,
    input  logic                  imemGnt,
    input  logic                  imemRValid,
    input  logic [INSTR_SIZE-1:0] imemRData,
    output logic [ADDR_SIZE-1:0]  PCOut,
    output logic [INSTR_SIZE-1:0] instrOut,
    output logic                  validOut
);

    logic [ADDR_SIZE-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]     outstanding_q, outstanding_d;
    logic [DROP_W-1:0]    drop_q, drop_d;
    logic [CNT_W-1:0]     buf_count_s;
    logic [CNT_W:0]       credit_used_s;
    logic                 buf_empty_s;
    logic                 grant_s;
    logic                 push_s;
    logic                 pop_s;
    logic [ADDR_SIZE-1:0] resp_pc_s;
    fetch_entry_t         push_entry_s;
    fetch_entry_t         head_s;

    assign credit_used_s = {1'b0, buf_count_s} + {1'b0, outstanding_q};
    assign imemReq       = !reset && !redirect && (credit_used_s < DEPTH_CREDITS);
    assign imemAddr      = fetch_pc_q;
    assign grant_s       = imemReq && imemGnt;

    // Responses are in order, so the oldest live request sits `outstanding` words behind fetchPC.
    assign resp_pc_s    = fetch_pc_q - {{(ADDR_SIZE-CNT_W-2){1'b0}}, outstanding_q, 2'b00};
    assign push_entry_s = '{pc: resp_pc_s, instr: imemRData};
    assign push_s       = imemRValid && (drop_q == {DROP_W{1'b0}}) && !redirect;
    assign pop_s        = !buf_empty_s && !stall && !redirect;

    fetch_buffer #(.DEPTH_P(DEPTH)) u_buffer (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .clear_i (redirect),
        .wdata_i (push_entry_s),
        .rdata_o (head_s),
        .count_o (buf_count_s),
        .empty_o (buf_empty_s)
    );

    assign validOut = !buf_empty_s;
    assign PCOut    = validOut ? head_s.pc : {ADDR_SIZE{1'b0}};
    assign instrOut = validOut ? head_s.instr : NOP_INSTR;

    // Next fetch PC and in-flight request accounting
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        if (redirect) begin
            fetch_pc_d    = align_word(redirectPC);
            outstanding_d = {CNT_W{1'b0}};
            drop_d        = drop_q + DROP_W'(outstanding_q) - DROP_W'(imemRValid);
        end else begin
            if (grant_s) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            case ({grant_s, push_s})
                2'b10:   outstanding_d = outstanding_q + 1'b1;
                2'b01:   outstanding_d = outstanding_q - 1'b1;
                default: outstanding_d = outstanding_q;
            endcase
            if (imemRValid && (drop_q != {DROP_W{1'b0}})) begin
                drop_d = drop_q - 1'b1;
            end else begin
                drop_d = drop_q;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= {CNT_W{1'b0}};
            drop_q        <= {DROP_W{1'b0}};
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: in-order memory model with variable
// latency, output scoreboard, startup vector table and corner-case sequences.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectPC;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt;
    logic        imemRValid;
    logic [31:0] imemRData;
    logic [31:0] PCOut;
    logic [31:0] instrOut;
    logic        validOut;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic [31:0] w_pc;
    logic [31:0] w_instr;
    logic        w_valid;

    fetch_stage u_dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirectPC(redirectPC),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemGnt(imemGnt), .imemRValid(imemRValid),
        .imemRData(imemRData), .PCOut(PCOut), .instrOut(instrOut), .validOut(validOut)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .reset(reset), .stall(1'b0), .redirect(1'b0), .redirectPC(32'h0000_0000),
        .imemReq(w_req), .imemAddr(w_addr), .imemGnt(1'b1), .imemRValid(w_rvalid),
        .imemRData(w_rdata), .PCOut(w_pc), .instrOut(w_instr), .validOut(w_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct {
        logic rst; logic st; logic g;
        logic exp_req; logic [31:0] exp_addr; logic exp_valid; logic [31:0] exp_pc;
    } vec_t;

    pend_t       pend[$];
    pend_t       w_pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] w_q[$];
    logic [31:0] exp_fetch;
    int          cyc = 0;
    int          lat = 1;
    int          checks = 0;
    int          failures = 0;
    int          w_pops = 0;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_instr;
    vec_t        vecs [9];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[31:2], 2'b11} ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out (cycle %0d)", name, cyc);
    endtask

    task automatic refill(output logic [31:0] q[$], input logic [31:0] base);
        logic [31:0] v;
        q.delete();
        v = base;
        for (int k = 0; k < 64; k++) begin
            q.push_back(v);
            v = v + 32'd4;
        end
    endtask

    // One clock cycle: drive inputs and memory responses, check outputs, track grants.
    task automatic tick(input logic rst_v, input logic st, input logic rd,
                        input logic [31:0] rpc, input logic g);
        logic resp_now, w_resp;
        logic [31:0] e;
        @(negedge clk);
        reset = rst_v; stall = st; redirect = rd; redirectPC = rpc; imemGnt = g;
        if (rst_v) begin
            pend.delete();
            w_pend.delete();
            exp_fetch = 32'h0000_0000;
            refill(exp_q, 32'h0000_0000);
            refill(w_q, 32'hFFFF_FFF8);
        end
        resp_now   = (pend.size() > 0) && (pend[0].due <= cyc);
        imemRValid = resp_now;
        imemRData  = resp_now ? instr_of(pend[0].addr) : 32'h0000_0000;
        w_resp     = (w_pend.size() > 0) && (w_pend[0].due <= cyc);
        w_rvalid   = w_resp;
        w_rdata    = w_resp ? instr_of(w_pend[0].addr) : 32'h0000_0000;
        #1;
        s_req = imemReq; s_addr = imemAddr; s_valid = validOut; s_pc = PCOut; s_instr = instrOut;
        if (imemReq) check("fetch_addr", imemAddr, exp_fetch);
        if (validOut && !st && !rd) begin
            if (exp_q.size() == 0) timeout("out_unexpected");
            else begin
                e = exp_q.pop_front();
                check("out_pc", PCOut, e);
                check("out_instr", instrOut, instr_of(e));
            end
        end
        if (imemReq && g) begin
            pend.push_back('{addr: imemAddr, due: cyc + lat});
            exp_fetch = exp_fetch + 32'd4;
        end
        if (resp_now) void'(pend.pop_front());
        if (rd) begin
            exp_fetch = {rpc[31:2], 2'b00};
            refill(exp_q, exp_fetch);
        end
        if (w_valid) begin
            w_pops++;
            if (w_q.size() == 0) timeout("wrap_unexpected");
            else begin
                e = w_q.pop_front();
                check("wrap_pc", w_pc, e);
                check("wrap_instr", w_instr, instr_of(e));
            end
        end
        if (w_req) w_pend.push_back('{addr: w_addr, due: cyc + 1});
        if (w_resp) void'(w_pend.pop_front());
        @(posedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        int n;
        logic [31:0] held;
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirectPC = 32'h0;
        imemGnt = 1'b0; imemRValid = 1'b0; imemRData = 32'h0;
        w_rvalid = 1'b0; w_rdata = 32'h0;
        exp_fetch = 32'h0;

        // rst, stall, gnt, exp_req, exp_addr, exp_valid, exp_pc
        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
`ifdef FETCH_PREFETCH_EN
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h8,  1'b1, 32'h4};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hC,  1'b0, 32'h0};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h8};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'hC};
`else
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h4};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h8,  1'b0, 32'h0};
`endif

        for (int i = 0; i < 9; i++) begin
            tick(vecs[i].rst, vecs[i].st, 1'b0, 32'h0, vecs[i].g);
            check("vec_req", s_req, vecs[i].exp_req);
            if (vecs[i].exp_req) check("vec_addr", s_addr, vecs[i].exp_addr);
            check("vec_valid", s_valid, vecs[i].exp_valid);
            check("vec_pc", s_pc, vecs[i].exp_pc);
            check("vec_instr", s_instr, vecs[i].exp_valid ? instr_of(vecs[i].exp_pc) : 32'h0000_0013);
        end

        // Stall while PC 0x10 is presented
        n = 0;
        while (exp_q[0] != 32'h10 && n < 100) begin run(1); n++; end
        if (n >= 100) timeout("reach_pc10");
        n = 0;
        do begin tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1); n++; end while (!s_valid && n < 20);
        if (!s_valid) timeout("stall_valid");
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
            check("stall_valid", s_valid, 1'b1);
            check("stall_pc", s_pc, 32'h10);
            check("stall_instr", s_instr, instr_of(32'h10));
        end
        check("stall_req_dropped", s_req, 1'b0);
        run(12);

        // Grant withheld for three cycles
        n = 0;
        do begin tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0); n++; end while (!s_req && n < 20);
        if (!s_req) timeout("gnt_low_req");
        held = s_addr;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            check("gnt_low_req", s_req, 1'b1);
            check("gnt_low_addr", s_addr, held);
        end
        run(10);

        // Asynchronous reset while the 0x40 request is in flight
        n = 0;
        while (exp_fetch != 32'h44 && n < 300) begin run(1); n++; end
        if (n >= 300) timeout("reach_pc40");
        #3;
        reset = 1'b1;
        #1;
        check("rst_valid", validOut, 1'b0);
        check("rst_pc", PCOut, 32'h0);
        check("rst_instr", instrOut, 32'h0000_0013);
        check("rst_req", imemReq, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("restart_req", s_req, 1'b1);
        check("restart_addr", s_addr, 32'h0);
        run(12);

        // Redirect with a stale request still in flight
        lat = 3;
        run(6);
        n = 0;
        while (!(pend.size() > 0 && pend[0].due > cyc) && n < 20) begin run(1); n++; end
        tick(1'b0, 1'b0, 1'b1, 32'h103, 1'b1);
        check("redir_req_low", s_req, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("redir_valid_low", s_valid, 1'b0);
        check("redir_next_req", s_req, 1'b1);
        check("redir_next_addr", s_addr, 32'h100);
        n = 0;
        while (exp_q[0] == 32'h100 && n < 40) begin run(1); n++; end
        if (n >= 40) timeout("redir_first_out");

        // Redirect in the very cycle a response returns
        lat = 2;
        run(4);
        n = 0;
        while (!(pend.size() > 0 && pend[0].due == cyc) && n < 20) begin run(1); n++; end
        if (n >= 20) timeout("resp_align");
        tick(1'b0, 1'b0, 1'b1, 32'h200, 1'b1);
        check("redir2_req_low", s_req, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("redir2_valid_low", s_valid, 1'b0);
        n = 0;
        while (exp_q[0] == 32'h200 && n < 40) begin run(1); n++; end
        if (n >= 40) timeout("redir2_first_out");
        run(8);

        check("wrap_outputs_seen", (w_pops >= 3) ? 32'd1 : 32'd0, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
